// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_seq sequencing unit: opcode values,
// FSM state encoding and the control strobe bundle.
package ctrl_pkg;

    localparam int unsigned OP_LDA  = 0;
    localparam int unsigned OP_LDB  = 1;
    localparam int unsigned OP_LDAI = 2;
    localparam int unsigned OP_LDBI = 3;
    localparam int unsigned OP_ADD  = 4;
    localparam int unsigned OP_SUB  = 5;
    localparam int unsigned OP_JMP  = 6;
    localparam int unsigned OP_JMP2 = 7;
    localparam int unsigned OP_JC   = 8;
    localparam int unsigned OP_JNC  = 9;
    localparam int unsigned OP_JZ   = 10;
    localparam int unsigned OP_JNZ  = 11;
    localparam int unsigned OP_HLT  = 12;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic aload;
        logic bload;
        logic dsel;
        logic rfload;
        logic str;
        logic opsel;
        logic jump;
    } strobe_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction memory request/valid interface.
//   master: sequencer side (drives imem_req/imem_addr)
//   slave : memory side (drives imem_valid/imem_data)
interface ctrl_seq_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [DATA_W-1:0] imem_data;

    modport master (output imem_req, imem_addr, input imem_valid, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_data);
endinterface

// File: rtl/ctrl_dec.sv
// Combinational opcode decoder.
//   op         : opcode field
//   flag_c/z   : registered flags used for conditional jumps
//   strb_c     : control strobes for the opcode (a false jump yields none)
//   take_jump_c: pc must be loaded with the jump target
//   go_halt_c  : opcode is HLT
module ctrl_dec
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    input  logic            flag_c,
    input  logic            flag_z,
    output strobe_t         strb_c,
    output logic            take_jump_c,
    output logic            go_halt_c
);

    logic cond;

    always_comb begin
        strb_c      = '0;
        take_jump_c = 1'b0;
        go_halt_c   = 1'b0;
        cond        = 1'b0;
        case (op)
            OP_W'(OP_LDA):  strb_c.aload = 1'b1;
            OP_W'(OP_LDB):  strb_c.bload = 1'b1;
            OP_W'(OP_LDAI): begin
                strb_c.aload = 1'b1;
                strb_c.dsel  = 1'b1;
            end
            OP_W'(OP_LDBI): begin
                strb_c.bload = 1'b1;
                strb_c.dsel  = 1'b1;
            end
            OP_W'(OP_ADD):  strb_c.rfload = 1'b1;
            OP_W'(OP_SUB):  begin
                strb_c.rfload = 1'b1;
                strb_c.opsel  = 1'b1;
            end
            OP_W'(OP_JMP), OP_W'(OP_JMP2): cond = 1'b1;
            OP_W'(OP_JC):   cond = flag_c;
            OP_W'(OP_JNC):  cond = ~flag_c;
            OP_W'(OP_JZ):   cond = flag_z;
            OP_W'(OP_JNZ):  cond = ~flag_z;
            OP_W'(OP_HLT):  begin
                strb_c.str = 1'b1;
                go_halt_c  = 1'b1;
            end
            default: ;
        endcase
        // Any jump opcode whose condition holds: str + jump
        if (cond) begin
            strb_c.str  = 1'b1;
            strb_c.jump = 1'b1;
            take_jump_c = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/execute sequencer for the accumulator CPU.
//   clk, rst         : clock, synchronous active-high reset
//   imem             : instruction fetch handshake (master)
//   carry_in/zero_in : ALU flags, latched at the end of an rfload EXEC
//   resume           : leave HALT
//   arg              : operand field of the IR
//   aload..jump      : one-cycle control strobes during EXEC
//   hlt              : high while halted
//   flag_c/flag_z    : latched flags
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned ARG_W  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    ctrl_seq_if.master       imem,
    input  logic             carry_in,
    input  logic             zero_in,
    input  logic             resume,
    output logic [ARG_W-1:0] arg,
    output logic             aload,
    output logic             bload,
    output logic             dsel,
    output logic             rfload,
    output logic             str,
    output logic             opsel,
    output logic             jump,
    output logic             hlt,
    output logic             flag_c,
    output logic             flag_z
);

    localparam int unsigned DATA_W = OP_W + ARG_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ARG_W-1:0]  arg_q, arg_d;
    logic              fc_q, fc_d, fz_q, fz_d;
    strobe_t           strb_q, strb_d;
    logic              jmp_q, jmp_d;
    logic              halt_q, halt_d;
    logic              req_q, req_d;
    logic              hlt_q, hlt_d;

    strobe_t           dec_strb;
    logic              dec_jump;
    logic              dec_halt;

    // The opcode half of the IR is decoded as it is fetched, so the EXEC
    // strobes come straight from registers. Flags cannot change between
    // fetch and EXEC, so the condition result is identical.
    ctrl_dec #(.OP_W(OP_W)) u_dec (
        .op          (imem.imem_data[DATA_W-1:ARG_W]),
        .flag_c      (fc_q),
        .flag_z      (fz_q),
        .strb_c      (dec_strb),
        .take_jump_c (dec_jump),
        .go_halt_c   (dec_halt)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            arg_q   <= '0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            strb_q  <= '0;
            jmp_q   <= 1'b0;
            halt_q  <= 1'b0;
            req_q   <= 1'b1;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            arg_q   <= arg_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            strb_q  <= strb_d;
            jmp_q   <= jmp_d;
            halt_q  <= halt_d;
            req_q   <= req_d;
            hlt_q   <= hlt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        arg_d   = arg_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        strb_d  = '0;
        jmp_d   = 1'b0;
        halt_d  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem.imem_valid) begin
                    arg_d   = imem.imem_data[ARG_W-1:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    strb_d  = dec_strb;
                    jmp_d   = dec_jump;
                    halt_d  = dec_halt;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (strb_q.rfload) begin
                    fc_d = carry_in;
                    fz_d = zero_in;
                end
                if (jmp_q) begin
                    pc_d = ADDR_W'(arg_q);
                end
                state_d = halt_q ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (resume) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        req_d = (state_d == S_FETCH);
        hlt_d = (state_d == S_HALT);
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign arg            = arg_q;
    assign aload          = strb_q.aload;
    assign bload          = strb_q.bload;
    assign dsel           = strb_q.dsel;
    assign rfload         = strb_q.rfload;
    assign str            = strb_q.str;
    assign opsel          = strb_q.opsel;
    assign jump           = strb_q.jump;
    assign hlt            = hlt_q;
    assign flag_c         = fc_q;
    assign flag_z         = fz_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: a cycle-by-cycle vector table followed by
// hand-written sequences for pc wrap-around and the unconditional jumps.
module tb_ctrl_seq;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned ARG_W  = 4;
    localparam int unsigned ADDR_W = 8;

    // Strobe order: {aload,bload,dsel,rfload,str,opsel,jump}
    localparam logic [6:0] SN  = 7'b0000000;
    localparam logic [6:0] SA  = 7'b1000000;
    localparam logic [6:0] SB  = 7'b0100000;
    localparam logic [6:0] SD  = 7'b0010000;
    localparam logic [6:0] SRF = 7'b0001000;
    localparam logic [6:0] SS  = 7'b0000100;
    localparam logic [6:0] SO  = 7'b0000010;
    localparam logic [6:0] SJ  = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst;
    logic             carry_in, zero_in, resume;
    logic [ARG_W-1:0] arg;
    logic             aload, bload, dsel, rfload, str, opsel, jump;
    logic             hlt, flag_c, flag_z;

    ctrl_seq_if #(.ADDR_W(ADDR_W), .DATA_W(OP_W + ARG_W)) imem ();

    ctrl_seq #(.OP_W(OP_W), .ARG_W(ARG_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .imem     (imem),
        .carry_in (carry_in),
        .zero_in  (zero_in),
        .resume   (resume),
        .arg      (arg),
        .aload    (aload),
        .bload    (bload),
        .dsel     (dsel),
        .rfload   (rfload),
        .str      (str),
        .opsel    (opsel),
        .jump     (jump),
        .hlt      (hlt),
        .flag_c   (flag_c),
        .flag_z   (flag_z)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        resume;
        logic        valid;
        logic [7:0]  data;
        logic        carry;
        logic        zero;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Observation word: {req, addr, strobes, hlt, flag_c, flag_z, arg}
    function automatic logic [22:0] ex(logic req, logic [7:0] addr, logic [6:0] s,
                                       logic h, logic c, logic z, logic [3:0] a);
        return {req, addr, s, h, c, z, a};
    endfunction

    function automatic logic [22:0] obs();
        return {imem.imem_req, imem.imem_addr,
                aload, bload, dsel, rfload, str, opsel, jump,
                hlt, flag_c, flag_z, arg};
    endfunction

    task automatic add(logic r, logic res, logic v, logic [7:0] d,
                       logic c, logic z, logic [22:0] e);
        vec_t x;
        x.rst = r; x.resume = res; x.valid = v; x.data = d;
        x.carry = c; x.zero = z; x.exp = e;
        vecs.push_back(x);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nz;
        rst = 1'b1; resume = 1'b0; carry_in = 1'b0; zero_in = 1'b0;
        imem.imem_valid = 1'b0; imem.imem_data = '0;

        // rst res v data c z -> req addr strobes hlt fc fz arg
        add(1,0,0,8'h00,0,0, ex(1,8'h00,SN,0,0,0,4'h0));     // reset
        add(0,0,1,8'h00,0,0, ex(0,8'h01,SA,0,0,0,4'h0));     // LDA 0
        add(0,0,0,8'h00,0,0, ex(1,8'h01,SN,0,0,0,4'h0));
        add(0,0,1,8'h11,0,0, ex(0,8'h02,SB,0,0,0,4'h1));     // LDB 1
        add(0,0,0,8'h00,0,0, ex(1,8'h02,SN,0,0,0,4'h1));
        add(0,0,1,8'h44,0,0, ex(0,8'h03,SRF,0,0,0,4'h4));    // ADD
        add(0,0,0,8'h00,0,1, ex(1,8'h03,SN,0,0,1,4'h4));     // flags <- c0 z1
        add(0,0,1,8'h40,0,0, ex(0,8'h04,SRF,0,0,1,4'h0));    // ADD
        add(0,0,0,8'h00,1,0, ex(1,8'h04,SN,0,1,0,4'h0));     // flags <- c1 z0
        add(0,0,1,8'h89,0,1, ex(0,8'h05,SS|SJ,0,1,0,4'h9));  // JC 9 taken
        add(0,0,0,8'h00,0,1, ex(1,8'h09,SN,0,1,0,4'h9));     // flags untouched
        add(0,0,1,8'h95,0,0, ex(0,8'h0A,SN,0,1,0,4'h5));     // JNC not taken
        add(0,0,0,8'h00,0,0, ex(1,8'h0A,SN,0,1,0,4'h5));
        add(0,0,1,8'hA3,0,0, ex(0,8'h0B,SN,0,1,0,4'h3));     // JZ not taken
        add(0,0,0,8'h00,0,0, ex(1,8'h0B,SN,0,1,0,4'h3));
        add(0,0,1,8'hB2,0,0, ex(0,8'h0C,SS|SJ,0,1,0,4'h2));  // JNZ taken
        add(0,0,0,8'h00,0,0, ex(1,8'h02,SN,0,1,0,4'h2));
        add(0,0,1,8'h27,0,0, ex(0,8'h03,SA|SD,0,1,0,4'h7));  // LDAI
        add(0,0,0,8'h00,0,0, ex(1,8'h03,SN,0,1,0,4'h7));
        add(0,0,1,8'h36,0,0, ex(0,8'h04,SB|SD,0,1,0,4'h6));  // LDBI
        add(0,0,0,8'h00,0,0, ex(1,8'h04,SN,0,1,0,4'h6));
        add(0,0,1,8'h50,0,0, ex(0,8'h05,SRF|SO,0,1,0,4'h0)); // SUB
        add(0,0,0,8'h00,0,1, ex(1,8'h05,SN,0,0,1,4'h0));     // flags <- c0 z1
        add(0,0,1,8'h8F,0,0, ex(0,8'h06,SN,0,0,1,4'hF));     // JC not taken
        add(0,0,0,8'h00,0,0, ex(1,8'h06,SN,0,0,1,4'hF));
        add(0,0,0,8'hC5,0,0, ex(1,8'h06,SN,0,0,1,4'hF));     // wait state 1
        add(0,1,0,8'hC5,0,0, ex(1,8'h06,SN,0,0,1,4'hF));     // wait 2, resume ignored
        add(0,0,0,8'hC5,0,0, ex(1,8'h06,SN,0,0,1,4'hF));     // wait state 3
        add(0,0,1,8'hC5,0,0, ex(0,8'h07,SS,0,0,1,4'h5));     // HLT at pc 6
        for (int i = 0; i < 10; i++)
            add(0,0,0,8'h00,0,0, ex(0,8'h07,SN,1,0,1,4'h5)); // halted
        add(0,1,0,8'h00,0,0, ex(1,8'h07,SN,0,0,1,4'h5));     // resume
        add(0,0,0,8'h00,0,0, ex(1,8'h07,SN,0,0,1,4'h5));
        add(1,0,1,8'h00,0,0, ex(1,8'h00,SN,0,0,0,4'h0));     // rst in fetch
        add(0,0,1,8'h40,0,0, ex(0,8'h01,SRF,0,0,0,4'h0));    // ADD
        add(0,0,0,8'h00,1,1, ex(1,8'h01,SN,0,1,1,4'h0));     // flags <- c1 z1
        add(0,0,1,8'hC1,0,0, ex(0,8'h02,SS,0,1,1,4'h1));     // HLT
        add(0,0,0,8'h00,0,0, ex(0,8'h02,SN,1,1,1,4'h1));
        add(1,1,0,8'h00,0,0, ex(1,8'h00,SN,0,0,0,4'h0));     // rst+resume in halt
        add(0,0,0,8'h00,0,0, ex(1,8'h00,SN,0,0,0,4'h0));

        foreach (vecs[i]) begin
            rst             = vecs[i].rst;
            resume          = vecs[i].resume;
            imem.imem_valid = vecs[i].valid;
            imem.imem_data  = vecs[i].data;
            carry_in        = vecs[i].carry;
            zero_in         = vecs[i].zero;
            step();
            check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
        end

        // Run 255 NOPs (opcodes 13..15) to bring pc to 255
        rst = 1'b0; resume = 1'b0; carry_in = 1'b0; zero_in = 1'b0;
        imem.imem_valid = 1'b1;
        nz = 0;
        for (int i = 0; i < 255; i++) begin
            imem.imem_data = {4'(13 + (i % 3)), 4'h0};
            step();
            if ({aload, bload, dsel, rfload, str, opsel, jump} != 7'd0) nz++;
            step();
        end
        check("nop_strobes", 32'(nz), 32'd0);
        check("pc_255", 32'(obs()), 32'(ex(1,8'hFF,SN,0,0,0,4'h0)));

        imem.imem_data = 8'hD0;
        step();
        check("nop_wrap", 32'(obs()), 32'(ex(0,8'h00,SN,0,0,0,4'h0)));
        step();
        check("fetch_0", 32'(obs()), 32'(ex(1,8'h00,SN,0,0,0,4'h0)));

        imem.imem_data = 8'h63;                              // JMP 3
        step();
        check("jmp_exec", 32'(obs()), 32'(ex(0,8'h01,SS|SJ,0,0,0,4'h3)));
        step();
        check("jmp_tgt", 32'(obs()), 32'(ex(1,8'h03,SN,0,0,0,4'h3)));

        imem.imem_data = 8'h7A;                              // JMP2 10
        step();
        check("jmp2_exec", 32'(obs()), 32'(ex(0,8'h04,SS|SJ,0,0,0,4'hA)));
        step();
        check("jmp2_tgt", 32'(obs()), 32'(ex(1,8'h0A,SN,0,0,0,4'hA)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Parametrised sequencing control unit for the small accumulator CPU. It replaces the purely combinational opcode decoder with a registered fetch/execute machine that owns the PC, the instruction register and a latched carry/zero flag register. It issues a request/valid handshake to instruction memory and drives one-cycle control strobes to the A/B registers, the register file and the ALU. HALT is a real state that can be left with a resume pulse.

Parameters:
OP_W, 4, opcode field width (upper bits of the instruction word); must be ≥4.
ARG_W, 4, operand/jump-target field width (lower bits of the instruction word).
ADDR_W, 8, PC width; the jump target is ARG_W zero-extended or truncated to ADDR_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; high throughout the FETCH state
imem_addr  out  ADDR_W  current PC
imem_valid  in  1  instruction word valid (sampled only while imem_req is high)
imem_data  in  OP_W+ARG_W  instruction word
carry_in  in  1  ALU carry, sampled at the end of an rfload EXEC cycle
zero_in  in  1  ALU zero, sampled at the end of an rfload EXEC cycle
resume  in  1  leave HALT
arg  out  ARG_W  operand field of the IR
aload, bload, dsel, rfload, str, opsel, jump  out  1 each  control strobes, high only during the EXEC cycle
hlt  out  1  high for the whole time the block is in HALT
flag_c, flag_z  out  1 each  latched flags

Behaviour:
- States: FETCH, EXEC, HALT. Reset state is FETCH.
- Reset state of the registers: pc=0, ir=0, flag_c=0, flag_z=0. All strobes and hlt are 0; imem_req is 1 in the first cycle after reset.
- Reset taken mid-fetch or in HALT discards the operation in progress. No strobe is issued on the reset cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - While imem_valid=0, stay in FETCH; wait states are unbounded.
  - On the cycle imem_valid=1: ir←imem_data, pc←pc+1 (wraps modulo 2^ADDR_W), next state is EXEC.
  - Fetch-to-strobe latency is one cycle after valid.
- EXEC lasts exactly one cycle and decodes the opcode ir[OP_W+ARG_W-1:ARG_W]:
  - 0: aload
  - 1: bload
  - 2: aload, dsel
  - 3: bload, dsel
  - 4: rfload (add)
  - 5: rfload, opsel (sub)
  - 6, 7: str, jump (unconditional)
  - 8: str, jump if flag_c=1
  - 9: str, jump if flag_c=0
  - 10: str, jump if flag_z=1
  - 11: str, jump if flag_z=0
  - 12: str, then enter HALT
  - All other opcodes: no strobes (NOP).
  - A conditional jump whose condition is false asserts no strobe at all.
  - Every strobe not listed for an opcode is 0 in every case. No output may hold an undriven or latched value.
- Conditions use the registered flags, never the live carry_in/zero_in.
- End of an EXEC cycle with rfload: flag_c←carry_in and flag_z←zero_in. No other opcode changes the flags.
- Taken jump: pc←arg (resized to ADDR_W), overriding the post-fetch increment.
- Next state after EXEC: HALT for opcode 12, otherwise FETCH.
- HALT:
  - hlt=1, imem_req=0, all strobes 0; pc holds the address after the HLT instruction.
  - resume=1 moves to FETCH on the next edge.
  - resume asserted outside HALT is ignored.
  - If rst and resume are both high, rst wins.
- arg = ir[ARG_W-1:0], driven continuously.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams: OP_LDA, OP_LDB, OP_LDAI, OP_LDBI, OP_ADD, OP_SUB, OP_JMP, OP_JMP2, OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_HLT;
  - the state encoding: S_FETCH, S_EXEC, S_HALT.
- One combinational sub-module, ctrl_dec: maps (opcode, flag_c, flag_z) to (strobe vector, take_jump, go_halt). The sequencer gates its strobes with state==EXEC.

Test Plan:
1. Reset release, then stream LDA(0x0), LDB(0x1), ADD(0x4) with imem_valid on the first request cycle. → aload, bload, rfload each pulse exactly one cycle, two cycles apart; pc reads 3 afterwards.
2. ADD with carry_in=1, zero_in=0, then JC 0x9, then JNC 0x5. → flag_c=1; JC asserts str and jump and the next imem_addr is 9; JNC asserts no strobes and pc simply increments.
3. Instruction memory holds imem_valid low for 3 cycles. → imem_req stays high with a stable imem_addr, no strobes meanwhile, and the IR is captured on the valid cycle.
4. HLT at pc=6. → str pulses for one cycle, then hlt=1 with imem_req=0 for 10 cycles; a one-cycle resume pulse gives imem_req=1 with imem_addr=7.
5. rst asserted during the FETCH wait state and again during HALT together with resume. → the next cycle shows pc=0, flags 0, hlt=0, imem_req=1, and no strobes.
6. pc=255 (ADDR_W=8) fetching a NOP (opcode 13). → no strobes asserted and pc wraps to 0.
